// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller driving the shared ALU and single-read-port register file.
// Optional retired-instruction counter enabled by defining ALU_SEQ_PERF_EN.
module alu_op_sequencer #(
  parameter int DW  = 8,
  parameter int AW  = 3,
  parameter int OPW = 2,
  parameter int PCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [OPW-1:0] instr_op,
  input  logic [AW-1:0]  instr_rd,
  input  logic [AW-1:0]  instr_rs1,
  input  logic [AW-1:0]  instr_rs2,
  output logic [AW-1:0]  rf_read_addr,
  input  logic [DW-1:0]  rf_read_data,
  output logic           rf_we,
  output logic [AW-1:0]  rf_write_addr,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_opcode,
  input  logic [DW-1:0]  alu_result,
  output logic           done,
  output logic [DW-1:0]  result,
  output logic           busy,
  output logic [PCW-1:0] retired_count
);

  typedef enum logic [2:0] {S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_WB} state_t;

  state_t         state, state_nxt;
  logic [OPW-1:0] op_q, opc_q;
  logic [AW-1:0]  rd_q, rs1_q, rs2_q;
  logic [DW-1:0]  a_q, b_q, res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      op_q  <= '0;
      opc_q <= '0;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (instr_valid) begin
          op_q  <= instr_op;
          rd_q  <= instr_rd;
          rs1_q <= instr_rs1;
          rs2_q <= instr_rs2;
        end
        S_RD_A: a_q <= rf_read_data;
        S_RD_B: begin
          b_q   <= rf_read_data;
          opc_q <= op_q;
        end
        // result is visible alongside done and held until the next write-back
        S_EXEC: res_q <= alu_result;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    instr_ready   = 1'b0;
    busy          = 1'b1;
    rf_read_addr  = '0;
    rf_we         = 1'b0;
    rf_write_addr = '0;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_nxt = S_RD_A;
      end
      S_RD_A: begin
        rf_read_addr = rs1_q;
        state_nxt    = S_RD_B;
      end
      S_RD_B: begin
        rf_read_addr = rs2_q;
        state_nxt    = S_EXEC;
      end
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        rf_we         = 1'b1;
        rf_write_addr = rd_q;
        done          = 1'b1;
        state_nxt     = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = opc_q;
  assign result     = res_q;

`ifdef ALU_SEQ_PERF_EN
  logic [PCW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (state == S_WB) cnt_q <= cnt_q + 1'b1;
  end
  assign retired_count = cnt_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with behavioural ALU + register file and a
// register-array reference model; directed scenarios then randomized instructions.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [1:0] instr_op;
  logic [2:0] instr_rd, instr_rs1, instr_rs2;
  logic [2:0] rf_read_addr;
  logic [7:0] rf_read_data;
  logic       rf_we;
  logic [2:0] rf_write_addr;
  logic [7:0] alu_a, alu_b;
  logic [1:0] alu_opcode;
  logic [7:0] alu_result;
  logic       done;
  logic [7:0] result;
  logic       busy;
  logic [15:0] retired_count;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_we(rf_we), .rf_write_addr(rf_write_addr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .done(done), .result(result), .busy(busy), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // datapath models: register file (not cleared by rst) and ALU
  logic [7:0] rf [8];
  initial for (int i = 0; i < 8; i++) rf[i] = 8'h00;
  always @(posedge clk) if (rf_we) rf[rf_write_addr] <= alu_result;
  assign rf_read_data = rf[rf_read_addr];

  always_comb begin
    case (alu_opcode)
      2'b00:   alu_result = alu_a & alu_b;
      2'b01:   alu_result = alu_a | alu_b;
      2'b10:   alu_result = ~(alu_a & alu_b);
      default: alu_result = ~(alu_a | alu_b);
    endcase
  end

  int we_cnt = 0;
  always @(posedge clk) if (rf_we) we_cnt <= we_cnt + 1;

  // reference model
  logic [7:0] mdl [8];
  int         ret_exp = 0;
  int         total = 0, bad = 0;

  function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ret_ref();
`ifdef ALU_SEQ_PERF_EN
    return 16'(ret_exp);
`else
    return 16'd0;
`endif
  endfunction

  // Entered and left on a negedge with the DUT idle; optionally leaves valid high.
  task automatic exec(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input bit hold_valid);
    logic [7:0] a, b, e;
    int w0;
    a = mdl[rs1]; b = mdl[rs2]; e = ref_op(op, a, b);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
    chk("ready_idle", instr_ready, 1);
    w0 = we_cnt;
    @(posedge clk); @(negedge clk);
    if (!hold_valid) instr_valid = 1'b0;
    instr_op = 2'($urandom); instr_rd = 3'($urandom);
    instr_rs1 = 3'($urandom); instr_rs2 = 3'($urandom);
    chk("c1_ready", instr_ready, 0);
    chk("c1_busy", busy, 1);
    chk("c1_raddr", rf_read_addr, rs1);
    chk("c1_we", rf_we, 0);
    @(negedge clk);
    chk("c2_raddr", rf_read_addr, rs2);
    chk("c2_alu_a", alu_a, a);
    chk("c2_done", done, 0);
    @(negedge clk);
    chk("c3_alu_b", alu_b, b);
    chk("c3_opc", alu_opcode, op);
    chk("c3_raddr", rf_read_addr, 0);
    chk("c3_we", rf_we, 0);
    @(negedge clk);
    chk("c4_we", rf_we, 1);
    chk("c4_waddr", rf_write_addr, rd);
    chk("c4_done", done, 1);
    chk("c4_result", result, e);
    chk("c4_ready", instr_ready, 0);
    mdl[rd] = e;
    ret_exp++;
    @(negedge clk);
    chk("c5_rf", rf[rd], e);
    chk("c5_we_cnt", we_cnt, w0 + 1);
    chk("c5_ready", instr_ready, 1);
    chk("c5_done", done, 0);
    chk("c5_result", result, e);
    chk("c5_retired", retired_count, ret_ref());
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", rf_we, 0);
    chk("rst_result", result, 0);
    chk("rst_alu", {alu_a, alu_b, 6'd0, alu_opcode}, 0);
    chk("rst_retired", retired_count, 0);
    rst = 1'b0;
    @(negedge clk);

    exec(2'd3, 3'd1, 3'd0, 3'd0, 1'b0);
    chk("t1_r1", rf[1], 8'hFF);
    exec(2'd0, 3'd3, 3'd1, 3'd1, 1'b0);
    chk("t2_r3", rf[3], 8'hFF);
    exec(2'd2, 3'd4, 3'd1, 3'd3, 1'b0);
    chk("t2_r4", rf[4], 8'h00);
    exec(2'd1, 3'd1, 3'd1, 3'd0, 1'b0);
    chk("t3_r1_or", rf[1], 8'hFF);
    exec(2'd3, 3'd1, 3'd1, 3'd0, 1'b0);
    chk("t3_r1_nor", rf[1], 8'h00);

    // valid held high across two instructions
    exec(2'd2, 3'd5, 3'd0, 3'd0, 1'b1);
    exec(2'd1, 3'd6, 3'd5, 3'd4, 1'b0);
    chk("t4_r6", rf[6], 8'hFF);

    // reset while in RD_B: no write, target unchanged
    begin
      int w0;
      logic [7:0] old;
      old = mdl[5];
      w0 = we_cnt;
      instr_valid = 1'b1; instr_op = 2'd3; instr_rd = 3'd5; instr_rs1 = 3'd0; instr_rs2 = 3'd0;
      @(posedge clk); @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t5_busy", busy, 0);
      chk("t5_ready", instr_ready, 1);
      chk("t5_we", rf_we, 0);
      ret_exp = 0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("t5_we_cnt", we_cnt, w0);
      chk("t5_rf", rf[5], old);
      chk("t5_result", result, 0);
      chk("t5_retired", retired_count, 0);
    end
    exec(2'd3, 3'd7, 3'd0, 3'd4, 1'b0);

    // randomized instructions with random idle gaps
    for (int n = 0; n < 40; n++) begin
      exec(2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom));
      instr_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk("final_rf", rf[i], mdl[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
